box_draw_arbiter: RTL

Shares the single pixel-plotting path (x, y, colour, plot to the VGA adapter) between up to four box-drawing requesters, such as the house painter, the screen clearer and the delivery-car sprite. Each requester asks for one 4x4 box at a base coordinate and colour. The block grants requesters round-robin, sequences the 16 pixels of the box one per cycle, clips off-screen pixels, and signals completion per requester. It sits between the game-level controllers and the VGA adapter and replaces per-controller drawing FSMs.

---
 rtl/draw_pkg.sv | 23 ++
 rtl/rr_arbiter4.sv | 26 ++
 rtl/box_draw_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module : draw_pkg
// Brief  : Shared screen limits, box geometry, widths and state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int BOX_DIM  = 4;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : draw_pkg
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter4
// Brief  : Combinational 4-way round-robin pick, first requester after last.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] grant_o,
    output logic       valid_o
);

    // Walk from farthest to nearest offset so the nearest requester wins.
    always_comb begin
        grant_o = last_grant_i;
        valid_o = |req_i;
        for (int i = 4; i >= 1; i--) begin
            if (req_i[last_grant_i + 2'(i)]) begin
                grant_o = last_grant_i + 2'(i);
            end
        end
    end

endmodule : rr_arbiter4
`default_nettype wire

// File: rtl/box_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module : box_draw_arbiter
// Brief  : Round-robin shared 4x4 box plotter with clipping for the VGA path.
// Rev    : 1.0  initial release
// ============================================================================
module box_draw_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = draw_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_pkg::SCREEN_H
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_x,
    input  logic [7*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy
);
    import draw_pkg::*;

    localparam logic [3:0]   CNT_LAST = 4'(BOX_DIM * BOX_DIM - 1);
    localparam logic [X_W:0] X_LIM    = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM    = (Y_W + 1)'(SCREEN_H);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [1:0]          last_q, g_q;
    logic [X_W-1:0]      bx_q, x_q;
    logic [Y_W-1:0]      by_q, y_q;
    logic [COL_W-1:0]    bc_q, col_q;
    logic                plot_q, busy_q;
    logic [NUM_REQ-1:0]  ack_q, done_q;

    logic [1:0]          w_grant;
    logic                w_valid;
    logic [X_W-1:0]      w_gx, w_px_d;
    logic [Y_W-1:0]      w_gy, w_py_d;
    logic [COL_W-1:0]    w_gc;
    logic [3:0]          w_cnt_d;
    logic                w_g_on, w_p_on;

    rr_arbiter4 u_arb (
        .req_i        (req),
        .last_grant_i (last_q),
        .grant_o      (w_grant),
        .valid_o      (w_valid)
    );

    assign w_gx    = req_x[X_W*w_grant +: X_W];
    assign w_gy    = req_y[Y_W*w_grant +: Y_W];
    assign w_gc    = req_colour[COL_W*w_grant +: COL_W];
    assign w_cnt_d = cnt_q + 4'd1;
    // Pixel for the next count is prepared a cycle early so outputs stay registered.
    assign w_px_d  = bx_q + {6'd0, w_cnt_d[1:0]};
    assign w_py_d  = by_q + {5'd0, w_cnt_d[3:2]};
    assign w_g_on  = ({1'b0, w_gx} < X_LIM) && ({1'b0, w_gy} < Y_LIM);
    assign w_p_on  = ({1'b0, w_px_d} < X_LIM) && ({1'b0, w_py_d} < Y_LIM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            g_q     <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bc_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (w_valid) begin
                        state_q <= ST_DRAW;
                        busy_q  <= 1'b1;
                        g_q     <= w_grant;
                        cnt_q   <= '0;
                        bx_q    <= w_gx;
                        by_q    <= w_gy;
                        bc_q    <= w_gc;
                        x_q     <= w_gx;
                        y_q     <= w_gy;
                        col_q   <= w_gc;
                        plot_q  <= w_g_on;
                        ack_q   <= NUM_REQ'(1) << w_grant;
                    end
                end
                ST_DRAW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        plot_q  <= 1'b0;
                        done_q  <= NUM_REQ'(1) << g_q;
                    end else begin
                        cnt_q  <= w_cnt_d;
                        x_q    <= w_px_d;
                        y_q    <= w_py_d;
                        col_q  <= bc_q;
                        plot_q <= w_p_on;
                    end
                end
                ST_DONE: begin
                    last_q  <= g_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    plot_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack    = ack_q;
    assign done   = done_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = col_q;
    assign plot   = plot_q;
    assign busy   = busy_q;

endmodule : box_draw_arbiter
`default_nettype wire
